// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared types and sizes for the packet-aware 1-to-4 stream demultiplexer
package stream_demux_pkg;
    localparam int NLANE = 4;
    localparam int CNT_W = 16;
    typedef logic [1:0] dest_t;
    typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry output register slot (valid/data/last) with load and drain
module demux_slot #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             full,
    output logic [WIDTH-1:0] data,
    output logic             last
);
    // a load wins over a drain in the same cycle so back-to-back beats keep full set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full <= 1'b0;
            data <= '0;
            last <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            data <= in_data;
            last <= in_last;
        end else if (drain && full) begin
            full <= 1'b0;
        end
    end
endmodule

// File: rtl/stream_demux4.sv
// stream_demux4: steers whole packets from one stream to four lanes; STREAM_DEMUX_CNT_EN adds per-lane packet counters
module stream_demux4
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic                          clk,
    input  logic                          reset_n,
`ifdef STREAM_DEMUX_CNT_EN
    input  logic                          cnt_clr,
    output logic [NLANE-1:0][CNT_W-1:0]   pkt_cnt,
`endif
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    input  dest_t                         in_dest,
    input  logic                          in_last,
    output logic [NLANE-1:0]              out_valid,
    input  logic [NLANE-1:0]              out_ready,
    output logic [NLANE-1:0][WIDTH-1:0]   out_data,
    output logic [NLANE-1:0]              out_last
);
    state_t state, state_nxt;
    dest_t  cur_dest, cur_dest_nxt, d;
    logic   accept;

    // head beats route by in_dest, body beats by the latched destination
    always_comb begin
        d            = (state == IDLE) ? in_dest : cur_dest;
        in_ready     = !out_valid[d] || out_ready[d];
        accept       = in_valid && in_ready;
        state_nxt    = state;
        cur_dest_nxt = cur_dest;
        if (accept && state == IDLE && !in_last) begin
            state_nxt    = BUSY;
            cur_dest_nxt = in_dest;
        end else if (accept && state == BUSY && in_last) begin
            state_nxt = IDLE;
        end
    end

    // packet tracking state; reset drops any partial packet
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cur_dest <= '0;
        end else begin
            state    <= state_nxt;
            cur_dest <= cur_dest_nxt;
        end
    end

    for (genvar i = 0; i < NLANE; i++) begin : g_slot
        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk     (clk),
            .reset_n (reset_n),
            .load    (accept && d == dest_t'(i)),
            .drain   (out_ready[i]),
            .in_data (in_data),
            .in_last (in_last),
            .full    (out_valid[i]),
            .data    (out_data[i]),
            .last    (out_last[i])
        );
    end

`ifdef STREAM_DEMUX_CNT_EN
    // saturating per-lane delivered-packet counters; clear drops the same-cycle increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_cnt <= '0;
        end else begin
            for (int i = 0; i < NLANE; i++) begin
                if (cnt_clr)
                    pkt_cnt[i] <= '0;
                else if (out_valid[i] && out_ready[i] && out_last[i] && pkt_cnt[i] != '1)
                    pkt_cnt[i] <= pkt_cnt[i] + 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_stream_demux4.sv
// tb_stream_demux4: randomized and directed bench with a queue-based lane scoreboard
module tb_stream_demux4;
    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [11:0]      in_data = '0;
    logic [1:0]       in_dest = '0;
    logic             in_last = 1'b0;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready = 4'hF;
    logic [3:0][11:0] out_data;
    logic [3:0]       out_last;
`ifdef STREAM_DEMUX_CNT_EN
    logic [3:0][15:0] pkt_cnt;
    logic             cnt_clr = 1'b0;
`endif
    int checks = 0;
    int passes = 0;

    stream_demux4 #(.WIDTH(12)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
`ifdef STREAM_DEMUX_CNT_EN
        .cnt_clr   (cnt_clr),
        .pkt_cnt   (pkt_cnt),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // reference model: each lane is a queue of {last,data} beats still owed to its consumer
    logic [12:0] q [4][$];
    logic        in_pkt = 1'b0;
    logic [1:0]  pkt_lane = '0;

    always @(negedge clk) begin
        int sz [4];
        logic [1:0] lane;
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) q[i].delete();
            in_pkt = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) sz[i] = q[i].size();
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (out_valid[i] !== (sz[i] != 0))
                    $display("FAIL sb_valid lane%0d got %b want %b", i, out_valid[i], sz[i] != 0);
                else
                    passes++;
                if (out_valid[i] === 1'b1 && sz[i] != 0) begin
                    checks++;
                    if ({out_last[i], out_data[i]} !== q[i][0])
                        $display("FAIL sb_beat lane%0d got %h want %h", i, {out_last[i], out_data[i]}, q[i][0]);
                    else
                        passes++;
                    if (out_ready[i]) void'(q[i].pop_front());
                end
            end
            lane = in_pkt ? pkt_lane : in_dest;
            checks++;
            if (in_ready !== (sz[lane] == 0 || out_ready[lane]))
                $display("FAIL sb_in_ready got %b want %b", in_ready, sz[lane] == 0 || out_ready[lane]);
            else
                passes++;
            if (in_valid && in_ready) begin
                q[lane].push_back({in_last, in_data});
                if (!in_pkt && !in_last) begin
                    in_pkt = 1'b1;
                    pkt_lane = in_dest;
                end else if (in_pkt && in_last) begin
                    in_pkt = 1'b0;
                end
            end
        end
    end

    // present one beat and hold it until accepted; returns just after the accepting edge
    task automatic beat(input logic [11:0] dt, input logic [1:0] ds, input logic lst, output int waited);
        in_valid = 1'b1;
        in_data  = dt;
        in_dest  = ds;
        in_last  = lst;
        waited   = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (waited >= 200) $display("FAIL beat_timeout data %h in_ready %b want 1", dt, in_ready);
        else passes++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom);
            in_data   = 12'($urandom);
            in_dest   = 2'($urandom);
            in_last   = 1'($urandom);
            out_ready = 4'($urandom);
            @(negedge clk);
            checks++;
            if (out_valid !== 4'b0) $display("FAIL reset_valid got %b want 0000", out_valid);
            else passes++;
            checks++;
            if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
            else passes++;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 4'hF;
        reset_n   = 1'b1;
`ifdef STREAM_DEMUX_CNT_EN
        checks++;
        if (pkt_cnt !== '0) $display("FAIL reset_pkt_cnt got %h want 0", pkt_cnt);
        else passes++;
`endif
    endtask

    task automatic test_multibeat();
        logic [11:0] dv [3];
        int w;
        dv[0] = 12'h0A1; dv[1] = 12'h0A2; dv[2] = 12'h0A3;
        for (int k = 0; k < 3; k++) begin
            beat(dv[k], (k == 0) ? 2'd2 : 2'd1, k == 2, w);
            if (k == 2) in_valid = 1'b0;
            checks++;
            if (out_valid !== 4'b0100) $display("FAIL multi_valid beat%0d got %b want 0100", k, out_valid);
            else passes++;
            checks++;
            if (out_data[2] !== dv[k] || out_last[2] !== (k == 2))
                $display("FAIL multi_data beat%0d got %h/%b want %h/%b", k, out_data[2], out_last[2], dv[k], k == 2);
            else passes++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        int w;
        out_ready = 4'b1101;
        beat(12'h0AA, 2'd1, 1'b1, w);
        in_data = 12'h111;
        in_dest = 2'd1;
        in_last = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) $display("FAIL stall_in_ready cyc%0d got %b want 0", k, in_ready);
            else passes++;
            checks++;
            if (out_valid[1] !== 1'b1 || out_data[1] !== 12'h0AA)
                $display("FAIL stall_hold cyc%0d got %b/%h want 1/0aa", k, out_valid[1], out_data[1]);
            else passes++;
        end
        @(posedge clk); #1;
        out_ready = 4'hF;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) $display("FAIL stall_release got %b want 1", in_ready);
        else passes++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid[1] !== 1'b1 || out_data[1] !== 12'h111)
            $display("FAIL stall_pass got %b/%h want 1/111", out_valid[1], out_data[1]);
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int w;
        out_ready = 4'hF;
        for (int k = 0; k < 4; k++) begin
            beat(12'h300 + 12'(k), 2'(k), 1'b1, w);
            checks++;
            if (w != 0) $display("FAIL b2b_stall lane%0d waited %0d want 0", k, w);
            else passes++;
            checks++;
            if (out_valid !== 4'(1 << k) || out_data[k] !== 12'h300 + 12'(k))
                $display("FAIL b2b_lane lane%0d got %b/%h want %b/%h", k, out_valid, out_data[k], 4'(1 << k), 12'h300 + 12'(k));
            else passes++;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int w;
        beat(12'h3B1, 2'd3, 1'b0, w);
        beat(12'h3B2, 2'd0, 1'b0, w);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        checks++;
        if (out_valid !== 4'b0) $display("FAIL midrst_valid got %b want 0000", out_valid);
        else passes++;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        beat(12'h0C0, 2'd0, 1'b1, w);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 4'b0001 || out_data[0] !== 12'h0C0)
            $display("FAIL midrst_route got %b/%h want 0001/0c0", out_valid, out_data[0]);
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        bit done = 1'b0;
        int w;
        fork
            begin
                for (int p = 0; p < 150; p++) begin
                    int len = $urandom_range(1, 4);
                    logic [1:0] ds = 2'($urandom);
                    for (int b = 0; b < len; b++) begin
                        if ($urandom_range(0, 3) == 0) begin
                            in_valid = 1'b0;
                            @(posedge clk); #1;
                        end
                        beat(12'($urandom), (b == 0) ? ds : 2'($urandom), b == len - 1, w);
                    end
                end
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = 4'($urandom);
                end
            end
        join
        out_ready = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q[i].size() != 0 || out_valid[i] !== 1'b0)
                $display("FAIL rand_drain lane%0d left %0d valid %b want 0", i, q[i].size(), out_valid[i]);
            else passes++;
        end
    endtask

`ifdef STREAM_DEMUX_CNT_EN
    task automatic test_counter();
        int w;
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        out_ready = 4'hF;
        for (int p = 0; p < 2; p++) beat(12'(p), 2'd0, 1'b1, w);
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (pkt_cnt[0] !== 16'd2) $display("FAIL cnt_two got %h want 0002", pkt_cnt[0]);
        else passes++;
        for (int p = 0; p < 65535; p++) beat(12'(p), 2'd0, 1'b1, w);
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (pkt_cnt[0] !== 16'hFFFF) $display("FAIL cnt_sat got %h want ffff", pkt_cnt[0]);
        else passes++;
        for (int k = 0; k < 2; k++) begin
            beat(12'h5A5, 2'd0, 1'b1, w);
            in_valid = 1'b0;
            cnt_clr  = 1'b1;
            @(posedge clk); #1;
            cnt_clr = 1'b0;
            checks++;
            if (pkt_cnt[0] !== 16'h0) $display("FAIL cnt_clr%0d got %h want 0000", k, pkt_cnt[0]);
            else passes++;
        end
        beat(12'h5A6, 2'd0, 1'b1, w);
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (pkt_cnt[0] !== 16'h1) $display("FAIL cnt_after_clr got %h want 0001", pkt_cnt[0]);
        else passes++;
    endtask
`endif

    initial begin
        test_reset();
        test_multibeat();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef STREAM_DEMUX_CNT_EN
        test_counter();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
